pov_column_scheduler: RTL and testbench



---
 rtl/pov_column_scheduler.sv | 172 +++++++++++++++++
 tb/tb_pov_column_scheduler.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pov_column_scheduler.sv
// POV column scheduler: synchronises the Hall pulse, measures the revolution period and
// slices each revolution into 2^LOG2_COLS column strobes, with an Avalon-MM control slave.
module pov_column_scheduler #(
  parameter int PERIOD_W   = 24,
  parameter int LOG2_COLS  = 7,
  parameter int MIN_PERIOD = 256
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  output logic                 irq,
  input  logic                 hall_in,
  output logic                 column_strobe,
  output logic [LOG2_COLS-1:0] column_index,
  output logic                 running
);

  localparam logic [LOG2_COLS:0]  COLS  = (LOG2_COLS+1)'(1 << LOG2_COLS);
  localparam logic [LOG2_COLS:0]  S_ONE = (LOG2_COLS+1)'(1);
  localparam logic [PERIOD_W:0]   MIN_P = (PERIOD_W+1)'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] P_ONE = PERIOD_W'(1);

  typedef enum logic [2:0] {IDLE, ACQUIRE, MEASURE, RUN, STALL} state_e;

  state_e               state_q;
  logic                 hallSync1_q, hallSync2_q;
  logic                 enable_q, enable_d;
  logic [1:0]           mask_q, mask_d;
  logic [LOG2_COLS-1:0] offset_q, offset_d;
  logic [1:0]           event_q, event_d, evtClr;
  logic [PERIOD_W-1:0]  period_q, periodCnt_q, interval_q, colTimer_q;
  logic [LOG2_COLS:0]   slotCnt_q;
  logic [LOG2_COLS-1:0] revOffset_q, columnIndex_q;
  logic                 strobe_q;
  logic [31:0]          readdata_q, rdMux;

  logic                 edgeDet, edgeOk, cntSat, measuring, revSet, stallSet, wrEn;
  logic [PERIOD_W:0]    cntPlus1;
  logic [PERIOD_W-1:0]  intervalShift, newInterval;
  logic                 unusedWriteBits;

  assign unusedWriteBits = ^writedata;

  assign edgeDet       = ~hallSync1_q & hallSync2_q;
  assign cntPlus1      = {1'b0, periodCnt_q} + {{PERIOD_W{1'b0}}, 1'b1};
  assign cntSat        = &periodCnt_q;
  assign edgeOk        = edgeDet && (cntPlus1 >= MIN_P);
  assign measuring     = (state_q == MEASURE) || (state_q == RUN);
  assign intervalShift = cntPlus1[PERIOD_W-1:0] >> LOG2_COLS;
  assign newInterval   = (intervalShift == '0) ? P_ONE : intervalShift;
  assign wrEn          = chipselect & ~write_n;

  // Register writes and event bookkeeping; a same-cycle set beats a write-1-clear.
  always_comb begin
    enable_d = enable_q;
    mask_d   = mask_q;
    offset_d = offset_q;
    evtClr   = '0;
    if (wrEn) begin
      case (address)
        2'd0:    begin enable_d = writedata[0]; mask_d = writedata[5:4]; end
        2'd2:    offset_d = writedata[LOG2_COLS-1:0];
        2'd3:    evtClr = writedata[1:0];
        default: ;
      endcase
    end
    stallSet = enable_d && measuring && cntSat;
    revSet   = enable_d && measuring && !cntSat && edgeOk;
    event_d  = (event_q & ~evtClr) | {stallSet, revSet};
  end

  always_comb begin
    rdMux = '0;
    case (address)
      2'd0: begin
        rdMux[0]   = enable_q;
        rdMux[1]   = (state_q == RUN);
        rdMux[2]   = (state_q == STALL);
        rdMux[5:4] = mask_q;
      end
      2'd1:    rdMux[PERIOD_W-1:0]  = period_q;
      2'd2:    rdMux[LOG2_COLS-1:0] = offset_q;
      default: rdMux[1:0]           = event_q;
    endcase
  end

  // Sequencer: clearing enable forces IDLE and silences strobes on the write edge itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      hallSync1_q   <= 1'b0;
      hallSync2_q   <= 1'b0;
      enable_q      <= 1'b0;
      mask_q        <= '0;
      offset_q      <= '0;
      event_q       <= '0;
      period_q      <= '0;
      periodCnt_q   <= '0;
      interval_q    <= '0;
      colTimer_q    <= '0;
      slotCnt_q     <= '0;
      revOffset_q   <= '0;
      columnIndex_q <= '0;
      strobe_q      <= 1'b0;
      readdata_q    <= '0;
    end else begin
      hallSync1_q <= hall_in;
      hallSync2_q <= hallSync1_q;
      enable_q    <= enable_d;
      mask_q      <= mask_d;
      offset_q    <= offset_d;
      event_q     <= event_d;
      readdata_q  <= rdMux;
      strobe_q    <= 1'b0;
      if (!enable_d) begin
        state_q       <= IDLE;
        periodCnt_q   <= '0;
        columnIndex_q <= '0;
      end else begin
        if (!cntSat) periodCnt_q <= periodCnt_q + P_ONE;
        case (state_q)
          IDLE: begin
            periodCnt_q <= '0;
            state_q     <= ACQUIRE;
          end
          ACQUIRE, STALL: begin
            if (edgeDet) begin
              periodCnt_q <= '0;
              state_q     <= MEASURE;
            end
          end
          MEASURE, RUN: begin
            if (cntSat) begin
              state_q <= STALL;
            end else if (edgeOk) begin
              state_q       <= RUN;
              period_q      <= cntPlus1[PERIOD_W-1:0];
              interval_q    <= newInterval;
              periodCnt_q   <= '0;
              strobe_q      <= 1'b1;
              columnIndex_q <= offset_q;
              revOffset_q   <= offset_q;
              slotCnt_q     <= S_ONE;
              colTimer_q    <= '0;
            end else if ((state_q == RUN) && (slotCnt_q != COLS)) begin
              if (colTimer_q == interval_q - P_ONE) begin
                colTimer_q    <= '0;
                slotCnt_q     <= slotCnt_q + S_ONE;
                strobe_q      <= 1'b1;
                columnIndex_q <= revOffset_q + slotCnt_q[LOG2_COLS-1:0];
              end else begin
                colTimer_q <= colTimer_q + P_ONE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign readdata      = readdata_q;
  assign irq           = |(event_q & mask_q);
  assign column_strobe = strobe_q;
  assign column_index  = columnIndex_q;
  assign running       = (state_q == RUN);

endmodule

// File: tb/tb_pov_column_scheduler.sv
// Scoreboard bench for pov_column_scheduler: directed Hall edge timing and register
// accesses push expectations; a monitor pops them on each strobe and each read return.
module tb_pov_column_scheduler;

  localparam int PW   = 14;
  localparam int LC   = 7;
  localparam int MINP = 256;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [1:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic          irq;
  logic          hall_in = 1'b1;
  logic          column_strobe;
  logic [LC-1:0] column_index;
  logic          running;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct { int cyc; int idx; } strobeExp_t;
  typedef struct { int cyc; logic [31:0] value; string name; } readExp_t;
  strobeExp_t strobeQ[$];
  readExp_t   readQ[$];

  // Revolution start times (pin fall cycles), hand-laid to match the test plan.
  localparam int T0 = 30;
  localparam int T1 = T0 + 12800;
  localparam int T2 = T1 + 12800;
  localparam int T3 = T2 + 12700;
  localparam int T4 = T3 + 13000;
  localparam int T5 = T4 + 13000;
  localparam int T6 = T5 + 16600;
  localparam int T7 = T6 + 300;

  pov_column_scheduler #(.PERIOD_W(PW), .LOG2_COLS(LC), .MIN_PERIOD(MINP)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
    .hall_in(hall_in), .column_strobe(column_strobe), .column_index(column_index),
    .running(running)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: strobes and read returns are compared against the scoreboard queues.
  strobeExp_t se;
  readExp_t   re;
  always @(negedge clk) begin
    if (reset_n && column_strobe) begin
      if (strobeQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL strobe_unexpected actual_cycle=%0d index=%0d expected=none", cyc, column_index);
      end else begin
        se = strobeQ.pop_front();
        checkOutput("strobe_cycle", 32'(cyc), 32'(se.cyc));
        checkOutput("strobe_index", 32'(column_index), 32'(se.idx));
      end
    end
    if (readQ.size() != 0 && readQ[0].cyc == cyc) begin
      re = readQ.pop_front();
      checkOutput(re.name, readdata, re.value);
    end
  end

  task automatic runUntil(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Hall pin falls at cycle t; a revolution start also loads its expected strobe train.
  task automatic applyStimulus(input int t, input bit isRev, input int interval,
                               input int off, input int cnt);
    runUntil(t);
    if (isRev) begin
      checkOutput("prior_rev_drained", 32'(strobeQ.size()), 32'd0);
      for (int k = 0; k < cnt; k++)
        strobeQ.push_back('{t + 2 + k * interval, (off + k) % (1 << LC)});
    end
    hall_in = 1'b0;
    repeat (4) @(negedge clk);
    hall_in = 1'b1;
  endtask

  task automatic writeReg(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic readReg(input logic [1:0] a, input logic [31:0] exp, input string name);
    @(negedge clk);
    address = a;
    readQ.push_back('{cyc + 1, exp, name});
    @(negedge clk);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #2;
    checkOutput("reset_readdata", readdata, 32'd0);
    checkOutput("reset_irq", 32'(irq), 32'd0);
    checkOutput("reset_strobe", 32'(column_strobe), 32'd0);
    checkOutput("reset_index", 32'(column_index), 32'd0);
    checkOutput("reset_running", 32'(running), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    writeReg(2'd0, 32'h21);
    readReg(2'd0, 32'h21, "ctrl_acquire");
    applyStimulus(T0, 1'b0, 0, 0, 0);
    readReg(2'd0, 32'h21, "ctrl_measure");

    applyStimulus(T1, 1'b1, 100, 0, 128);
    readReg(2'd1, 32'h3200, "period_12800");
    readReg(2'd0, 32'h23, "ctrl_run");
    readReg(2'd3, 32'h1, "event_rev");
    checkOutput("irq_rev_masked", 32'(irq), 32'd0);
    writeReg(2'd1, 32'hFFFF);
    readReg(2'd1, 32'h3200, "period_readonly");
    writeReg(2'd3, 32'h1);
    readReg(2'd3, 32'h0, "event_rev_cleared");

    applyStimulus(T2, 1'b1, 100, 0, 127);
    applyStimulus(T3, 1'b1, 99, 0, 128);
    readReg(2'd1, 32'h319C, "period_12700");
    runUntil(T3 + 5000);
    writeReg(2'd2, 32'd120);
    readReg(2'd2, 32'd120, "offset_rw");

    applyStimulus(T4, 1'b1, 101, 120, 128);
    applyStimulus(T4 + 100, 1'b0, 0, 0, 0);
    readReg(2'd1, 32'h32C8, "period_after_glitch");
    readReg(2'd0, 32'h23, "ctrl_after_glitch");

    applyStimulus(T5, 1'b1, 101, 120, 128);
    readReg(2'd3, 32'h1, "event_rev_again");
    runUntil(T5 + 16500);
    checkOutput("stall_no_pending_strobes", 32'(strobeQ.size()), 32'd0);
    checkOutput("irq_stall", 32'(irq), 32'd1);
    checkOutput("running_stall", 32'(running), 32'd0);
    readReg(2'd0, 32'h25, "ctrl_stall");
    readReg(2'd3, 32'h3, "event_stall");
    writeReg(2'd3, 32'h2);
    checkOutput("irq_stall_cleared", 32'(irq), 32'd0);
    readReg(2'd3, 32'h1, "event_stall_cleared");

    applyStimulus(T6, 1'b0, 0, 0, 0);
    readReg(2'd0, 32'h21, "ctrl_remeasure");
    applyStimulus(T7, 1'b1, 2, 120, 10);
    runUntil(T7 + 21);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midrun_reset_readdata", readdata, 32'd0);
    checkOutput("midrun_reset_strobe", 32'(column_strobe), 32'd0);
    checkOutput("midrun_reset_index", 32'(column_index), 32'd0);
    checkOutput("midrun_reset_running", 32'(running), 32'd0);
    checkOutput("midrun_reset_irq", 32'(irq), 32'd0);
    checkOutput("midrun_strobes_drained", 32'(strobeQ.size()), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    readReg(2'd1, 32'h0, "period_after_reset");
    readReg(2'd0, 32'h0, "ctrl_after_reset");
    readReg(2'd2, 32'h0, "offset_after_reset");
    repeat (2) @(negedge clk);
    checkOutput("reads_drained", 32'(readQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

endmodule
